// File: rtl/cm0_dbgslv_arbiter_if.sv
// cm0_dbgslv_arbiter_if: pipelined debug slave bus, one instance per master or core port
//   master modport: drives trans/size/write/addr/wdata, receives rdata/ready/resp
//   slave modport : the opposite direction
interface cm0_dbgslv_arbiter_if;
  logic [1:0]  trans;
  logic [1:0]  size;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        resp;
  modport master (output trans, size, write, addr, wdata, input rdata, ready, resp);
  modport slave  (input trans, size, write, addr, wdata, output rdata, ready, resp);
endinterface

// File: rtl/cm0_dbgslv_arbiter.sv
// cm0_dbgslv_arbiter: shares the core debug slave port between two debug masters
//   clk   : debug clock
//   rst_n : asynchronous active-low debug reset
//   m0/m1 : debug master ports (slave modport), each with a one-entry address hold register
//   s     : core slave port (master modport)
//   ARB_RR: 1 = round-robin between contenders, 0 = m0 always wins a contest
module cm0_dbgslv_arbiter #(
  parameter bit ARB_RR = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  cm0_dbgslv_arbiter_if.slave  m0,
  cm0_dbgslv_arbiter_if.slave  m1,
  cm0_dbgslv_arbiter_if.master s
);
  logic [1:0][1:0]  m_trans, m_size, h_trans, h_size, c_trans, c_size;
  logic [1:0][31:0] m_addr, m_wdata, h_addr, c_addr;
  logic [1:0]       m_write, h_write, c_write, m_ready, hold_vld, live, cand, taken;
  logic             lock, lock_id, rr_last, own_vld, own_id, gnt, any, accept;
  assign m_trans = {m1.trans, m0.trans};
  assign m_size  = {m1.size, m0.size};
  assign m_write = {m1.write, m0.write};
  assign m_addr  = {m1.addr, m0.addr};
  assign m_wdata = {m1.wdata, m0.wdata};
  // a master stalls while its transfer waits in the hold register or owns a stalled data phase
  assign m_ready[0] = (own_vld && !own_id) ? s.ready : !hold_vld[0];
  assign m_ready[1] = (own_vld && own_id) ? s.ready : !hold_vld[1];
  assign live = {m_trans[1][1] & m_ready[1], m_trans[0][1] & m_ready[0]};
  assign cand = hold_vld | live;
  always_comb
    for (int i = 0; i < 2; i++) begin
      c_trans[i] = hold_vld[i] ? h_trans[i] : m_trans[i];
      c_size[i]  = hold_vld[i] ? h_size[i]  : m_size[i];
      c_write[i] = hold_vld[i] ? h_write[i] : m_write[i];
      c_addr[i]  = hold_vld[i] ? h_addr[i]  : m_addr[i];
    end
  // a stalled address phase keeps its grant; its candidate is always the hold register
  assign gnt = lock ? lock_id :
               (cand == 2'b10) ? 1'b1 :
               (cand == 2'b11) ? (ARB_RR ? !rr_last : 1'b0) : 1'b0;
  assign any    = |cand;
  assign accept = any & s.ready;
  assign taken  = {accept & gnt, accept & !gnt};
  assign s.trans = any ? c_trans[gnt] : 2'b00;
  assign s.size  = any ? c_size[gnt]  : 2'b00;
  assign s.write = any ? c_write[gnt] : 1'b0;
  assign s.addr  = any ? c_addr[gnt]  : 32'h0;
  assign s.wdata = own_vld ? m_wdata[own_id] : 32'h0;
  assign m0.ready = m_ready[0];
  assign m1.ready = m_ready[1];
  assign m0.rdata = (own_vld && !own_id) ? s.rdata : 32'h0;
  assign m1.rdata = (own_vld && own_id) ? s.rdata : 32'h0;
  assign m0.resp  = own_vld && !own_id && s.resp;
  assign m1.resp  = own_vld && own_id && s.resp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_vld <= '0;
      h_trans  <= '0;
      h_size   <= '0;
      h_write  <= '0;
      h_addr   <= '0;
      lock     <= 1'b0;
      lock_id  <= 1'b0;
      rr_last  <= 1'b1;
      own_vld  <= 1'b0;
      own_id   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (live[i] && !taken[i]) begin
          hold_vld[i] <= 1'b1;
          h_trans[i]  <= m_trans[i];
          h_size[i]   <= m_size[i];
          h_write[i]  <= m_write[i];
          h_addr[i]   <= m_addr[i];
        end else if (taken[i]) hold_vld[i] <= 1'b0;
      lock    <= any & !s.ready;
      lock_id <= gnt;
      if (accept) rr_last <= gnt;
      if (s.ready) begin
        own_vld <= accept;
        own_id  <= gnt;
      end
    end
endmodule

// File: tb/tb_cm0_dbgslv_arbiter.sv
// tb_cm0_dbgslv_arbiter: directed checks of the debug slave arbiter in round-robin and fixed-priority builds
module tb_cm0_dbgslv_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  cm0_dbgslv_arbiter_if a0 ();
  cm0_dbgslv_arbiter_if a1 ();
  cm0_dbgslv_arbiter_if as ();
  cm0_dbgslv_arbiter_if f0 ();
  cm0_dbgslv_arbiter_if f1 ();
  cm0_dbgslv_arbiter_if fs ();
  cm0_dbgslv_arbiter #(.ARB_RR(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .m0(a0.slave), .m1(a1.slave), .s(as.master));
  cm0_dbgslv_arbiter #(.ARB_RR(1'b0)) dutf (.clk(clk), .rst_n(rst_n), .m0(f0.slave), .m1(f1.slave), .s(fs.master));
  assign f0.trans = a0.trans;
  assign f0.size  = a0.size;
  assign f0.write = a0.write;
  assign f0.addr  = a0.addr;
  assign f0.wdata = a0.wdata;
  assign f1.trans = a1.trans;
  assign f1.size  = a1.size;
  assign f1.write = a1.write;
  assign f1.addr  = a1.addr;
  assign f1.wdata = a1.wdata;
  assign fs.rdata = as.rdata;
  assign fs.ready = as.ready;
  assign fs.resp  = as.resp;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    a0.trans = 2'b00;
    a1.trans = 2'b00;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic req(input int m, input logic wr, input logic [31:0] ad);
    if (m == 0) begin
      a0.trans = 2'b10; a0.write = wr; a0.addr = ad; a0.size = 2'b10;
    end else begin
      a1.trans = 2'b10; a1.write = wr; a1.addr = ad; a1.size = 2'b10;
    end
  endtask
  initial begin
    a0.trans = '0; a0.size = '0; a0.write = '0; a0.addr = '0; a0.wdata = '0;
    a1.trans = '0; a1.size = '0; a1.write = '0; a1.addr = '0; a1.wdata = '0;
    as.rdata = '0; as.ready = 1'b1; as.resp = 1'b0;
    #2;
    chk("rst_trans", 32'(as.trans), 32'h0);
    chk("rst_addr", as.addr, 32'h0);
    chk("rst_rdy0", 32'(a0.ready), 32'h1);
    chk("rst_rdy1", 32'(a1.ready), 32'h1);
    chk("rst_rdata0", a0.rdata, 32'h0);
    chk("rst_resp1", 32'(a1.resp), 32'h0);
    tick();
    rst_n = 1'b1;
    // solo M0 read
    req(0, 1'b0, 32'hE000EDF0);
    #2;
    chk("solo_trans", 32'(as.trans), 32'h2);
    chk("solo_addr", as.addr, 32'hE000EDF0);
    chk("solo_size", 32'(as.size), 32'h2);
    chk("solo_rdy1", 32'(a1.ready), 32'h1);
    tick();
    idle();
    as.rdata = 32'h12345678;
    #2;
    chk("solo_rdata0", a0.rdata, 32'h12345678);
    chk("solo_rdy0", 32'(a0.ready), 32'h1);
    chk("solo_rdata1", a1.rdata, 32'h0);
    chk("solo_idle", 32'(as.trans), 32'h0);
    tick();
    as.rdata = 32'h0;
    #2;
    chk("solo_done", a0.rdata, 32'h0);
    // simultaneous requests from reset pointer
    do_reset();
    req(0, 1'b0, 32'hA0);
    req(1, 1'b0, 32'hB0);
    #2;
    chk("sim_first", as.addr, 32'hA0);
    tick();
    idle();
    as.rdata = 32'hD0;
    #2;
    chk("sim_second", as.addr, 32'hB0);
    chk("sim_trans", 32'(as.trans), 32'h2);
    chk("sim_rdata0", a0.rdata, 32'hD0);
    chk("sim_rdy1_wait", 32'(a1.ready), 32'h0);
    tick();
    as.rdata = 32'hD1;
    #2;
    chk("sim_rdy1", 32'(a1.ready), 32'h1);
    chk("sim_rdata1", a1.rdata, 32'hD1);
    chk("sim_rdata0_clr", a0.rdata, 32'h0);
    chk("sim_idle", 32'(as.trans), 32'h0);
    tick();
    // core stall for three cycles
    as.rdata = 32'h0;
    as.ready = 1'b0;
    req(0, 1'b0, 32'hC0);
    #2;
    chk("stall_a", as.addr, 32'hC0);
    tick();
    idle();
    req(1, 1'b0, 32'hC1);
    #2;
    chk("stall_b", as.addr, 32'hC0);
    chk("stall_rdy0", 32'(a0.ready), 32'h0);
    tick();
    idle();
    #2;
    chk("stall_c", as.addr, 32'hC0);
    chk("stall_rdy1", 32'(a1.ready), 32'h0);
    tick();
    as.ready = 1'b1;
    #2;
    chk("stall_go", as.addr, 32'hC0);
    tick();
    as.rdata = 32'hE0;
    #2;
    chk("stall_next", as.addr, 32'hC1);
    chk("stall_rdata0", a0.rdata, 32'hE0);
    chk("stall_rdy1_wait", 32'(a1.ready), 32'h0);
    tick();
    as.rdata = 32'hE1;
    #2;
    chk("stall_rdata1", a1.rdata, 32'hE1);
    chk("stall_rdy1_done", 32'(a1.ready), 32'h1);
    tick();
    as.rdata = 32'h0;
    // back-to-back contention: RR alternates, fixed keeps M0
    req(0, 1'b0, 32'h100);
    req(1, 1'b0, 32'h200);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("rr_grant%0d", k), as.addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      chk($sformatf("fix_grant%0d", k), fs.addr, 32'h100);
      tick();
    end
    idle();
    repeat (3) tick();
    // M1 write held behind M0, then error response
    do_reset();
    req(0, 1'b0, 32'h10);
    req(1, 1'b1, 32'h20);
    #2;
    chk("wr_first", as.addr, 32'h10);
    chk("wr_first_w", 32'(as.write), 32'h0);
    tick();
    idle();
    a1.wdata = 32'hDEADBEEF;
    #2;
    chk("wr_held", as.addr, 32'h20);
    chk("wr_held_w", 32'(as.write), 32'h1);
    chk("wr_wdata_m0", as.wdata, 32'h0);
    chk("wr_rdy1", 32'(a1.ready), 32'h0);
    tick();
    as.resp = 1'b1;
    #2;
    chk("wr_wdata", as.wdata, 32'hDEADBEEF);
    chk("wr_resp1", 32'(a1.resp), 32'h1);
    chk("wr_resp0", 32'(a0.resp), 32'h0);
    chk("wr_rdy1_done", 32'(a1.ready), 32'h1);
    tick();
    as.resp = 1'b0;
    a1.wdata = 32'h0;
    tick();
    // async reset while M1 is held
    req(0, 1'b0, 32'h30);
    req(1, 1'b0, 32'h40);
    tick();
    idle();
    #2;
    chk("rh_held", as.addr, 32'h40);
    rst_n = 1'b0;
    #1;
    chk("rh_trans", 32'(as.trans), 32'h0);
    chk("rh_rdy0", 32'(a0.ready), 32'h1);
    chk("rh_rdy1", 32'(a1.ready), 32'h1);
    tick();
    chk("rh_trans2", 32'(as.trans), 32'h0);
    rst_n = 1'b1;
    tick();
    #2;
    chk("rh_stale", 32'(as.trans), 32'h0);
    chk("rh_rdy1_after", 32'(a1.ready), 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
